// File: rtl/fft_sample_buffer.sv
// Sample buffer ahead of the FFT: load sequencer, 2048x10 single-port RAM, read sequencer.
// Optional READBACK_LOOP_EN makes the read sequencer sweep the RAM continuously.
module fft_sample_buffer #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              do_load,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              write_enable,
  output logic              data_loaded,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              read_done
);

  typedef enum logic [1:0] {IDLE, LOAD, READ, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic                do_load_prev_q;
  logic [ADDR_W-1:0]   load_addr_q, load_addr_d;
  logic                data_loaded_q, data_loaded_d;
  logic                rd_en_q;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_valid_q, rd_valid_d;
  logic                read_done_q, read_done_d;

  logic                load_rise;
  logic                rd_issue;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_dout;
  logic [DATA_W-1:0]   mem [DEPTH];

  // State register and all control flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      do_load_prev_q <= 1'b0;
      load_addr_q    <= '0;
      data_loaded_q  <= 1'b0;
      rd_en_q        <= 1'b0;
      rd_addr_q      <= '0;
      rd_valid_q     <= 1'b0;
      read_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      do_load_prev_q <= do_load;
      load_addr_q    <= load_addr_d;
      data_loaded_q  <= data_loaded_d;
      rd_en_q        <= data_loaded_q;
      rd_addr_q      <= rd_addr_d;
      rd_valid_q     <= rd_valid_d;
      read_done_q    <= read_done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (load_rise) state_d = LOAD;
      LOAD: if (sample_valid && (load_addr_q == LAST_ADDR)) state_d = READ;
      READ: begin
`ifndef READBACK_LOOP_EN
        if (rd_issue && (rd_addr_q == LAST_ADDR)) state_d = DONE;
`endif
        if (load_rise) state_d = LOAD;
      end
      DONE: if (load_rise) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer datapath.
  always_comb begin
    load_addr_d   = load_addr_q;
    data_loaded_d = data_loaded_q;
    rd_addr_d     = rd_addr_q;
    rd_valid_d    = rd_issue;
    read_done_d   = read_done_q;
    case (state_q)
      IDLE: if (load_rise) load_addr_d = '0;
      LOAD: begin
        if (sample_valid) begin
          if (load_addr_q == LAST_ADDR) data_loaded_d = 1'b1;
          else                          load_addr_d   = load_addr_q + ADDR_W'(1);
        end
      end
      READ: begin
`ifdef READBACK_LOOP_EN
        read_done_d = 1'b0;
`endif
        if (rd_issue) begin
          if (rd_addr_q == LAST_ADDR) begin
            // read_done lines up with the rd_valid of the last word
            read_done_d = 1'b1;
`ifdef READBACK_LOOP_EN
            rd_addr_d   = '0;
`endif
          end else begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
          end
        end
      end
      default: ;
    endcase
    if (load_rise && ((state_q == READ) || (state_q == DONE))) begin
      load_addr_d   = '0;
      data_loaded_d = 1'b0;
      rd_addr_d     = '0;
      rd_valid_d    = 1'b0;
      read_done_d   = 1'b0;
    end
  end

  // Outputs and RAM control.
  always_comb begin
    load_rise    = do_load & ~do_load_prev_q;
    write_enable = (state_q == LOAD);
    rd_issue     = (state_q == READ) && rd_en_q;
    ram_we       = write_enable && sample_valid && !rst;
    ram_addr     = write_enable ? load_addr_q : rd_addr_q;
    data_loaded  = data_loaded_q;
    rd_addr      = rd_addr_q;
    rd_valid     = rd_valid_q;
    read_done    = read_done_q;
    rd_data      = rd_valid_q ? ram_dout : '0;
  end

  // No reset on the array or its output register so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (ram_we)   mem[ram_addr] <= sample_in;
    if (rd_issue) ram_dout      <= mem[ram_addr];
  end

endmodule

// File: tb/tb_fft_sample_buffer.sv
// Directed self-checking bench for fft_sample_buffer (single-pass and READBACK_LOOP_EN builds).
module tb_fft_sample_buffer;
  localparam int DATA_W = 10;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2048;

  logic              clk = 1'b0;
  logic              rst;
  logic              do_load;
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              write_enable;
  logic              data_loaded;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              read_done;

  int n_checks = 0;
  int n_err    = 0;
  logic [DATA_W-1:0] model [DEPTH];

  fft_sample_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .do_load(do_load), .sample_in(sample_in),
    .sample_valid(sample_valid), .write_enable(write_enable),
    .data_loaded(data_loaded), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .read_done(read_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] pat(input int sel, input int idx);
    logic [31:0] i;
    i = idx;
    case (sel)
      0:       return i[9:0] ^ 10'h155;
      1:       return 10'h3FF;
      default: return 10'(idx * 3 + 1);
    endcase
  endfunction

  // Feeds samples while write_enable is high; stall=1 offers valid on every third LOAD cycle.
  task automatic fill(input string nm, input int sel, input int stall, input int exp_we);
    int   acc = 0;
    int   we_cyc = 0;
    int   ph = 0;
    logic seen_dl = 1'b0;
    logic v;
    do_load = 1'b1;
    sample_valid = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      step();
      if (i == 0) chk({nm, "_start_dl"}, 32'(data_loaded), 32'd0);
      if (data_loaded) begin
        seen_dl = 1'b1;
        break;
      end
      if (write_enable) begin
        we_cyc++;
        v = (stall == 0) || (ph % 3 == 0);
        ph++;
        if (v && acc < DEPTH) begin
          sample_valid = 1'b1;
          sample_in    = pat(sel, acc);
          model[acc]   = pat(sel, acc);
          acc++;
        end else begin
          sample_valid = 1'b0;
          sample_in    = 10'($urandom);
        end
      end else begin
        sample_valid = 1'b0;
      end
    end
    sample_valid = 1'b0;
    chk({nm, "_dl_seen"}, 32'(seen_dl), 32'd1);
    chk({nm, "_accepted"}, 32'(acc), 32'(DEPTH));
    chk({nm, "_we_low"}, 32'(write_enable), 32'd0);
    if (exp_we > 0) chk({nm, "_we_cycles"}, 32'(we_cyc), 32'(exp_we));
  endtask

  // Follows the read sweep; abort_at>=0 raises do_load when rd_addr reaches that value.
  task automatic readback(input string nm, input int abort_at, input int passes);
    int   vcnt = 0, bad = 0, gaps = 0, done_bad = 0, we_bad = 0, first_v = -1;
    logic started = 1'b0;
    logic exp_done;
    logic [ADDR_W-1:0] prev_addr;
    for (int k = 1; k <= passes * DEPTH + 20; k++) begin
      prev_addr = rd_addr;
      step();
      if (write_enable) we_bad++;
      if (rd_valid) begin
        if (!started) first_v = k;
        started = 1'b1;
        if (rd_data !== model[vcnt % DEPTH] || prev_addr !== ADDR_W'(vcnt % DEPTH)) bad++;
        vcnt++;
      end else if (started) begin
        gaps++;
      end
`ifdef READBACK_LOOP_EN
      exp_done = rd_valid && (vcnt > 0) && (vcnt % DEPTH == 0);
`else
      exp_done = (vcnt >= DEPTH);
`endif
      if (read_done !== exp_done) done_bad++;
      if (abort_at >= 0) begin
        if (rd_addr == ADDR_W'(50)) do_load = 1'b0;
        if (rd_addr == ADDR_W'(abort_at)) begin
          do_load = 1'b1;
          step();
          chk({nm, "_data_bad"}, 32'(bad), 32'd0);
          chk({nm, "_abort_dl"}, 32'(data_loaded), 32'd0);
          chk({nm, "_abort_vld"}, 32'(rd_valid), 32'd0);
          chk({nm, "_abort_we"}, 32'(write_enable), 32'd1);
          chk({nm, "_abort_addr"}, 32'(rd_addr), 32'd0);
          chk({nm, "_abort_done"}, 32'(read_done), 32'd0);
          return;
        end
      end else if (vcnt == passes * DEPTH) begin
        break;
      end
    end
    chk({nm, "_first_valid"}, 32'(first_v), 32'd2);
    chk({nm, "_valid_count"}, 32'(vcnt), 32'(passes * DEPTH));
    chk({nm, "_data_bad"}, 32'(bad), 32'd0);
    chk({nm, "_gaps"}, 32'(gaps), 32'd0);
    chk({nm, "_done_bad"}, 32'(done_bad), 32'd0);
    chk({nm, "_we_during_read"}, 32'(we_bad), 32'd0);
  endtask

  task automatic hold_done(input string nm);
    int bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (write_enable || rd_valid || !read_done || !data_loaded) bad++;
    end
    chk({nm, "_hold"}, 32'(bad), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      do_load      = 1'($urandom);
      sample_valid = 1'($urandom);
      sample_in    = 10'($urandom);
      step();
    end
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_dl", 32'(data_loaded), 32'd0);
    chk("rst_vld", 32'(rd_valid), 32'd0);
    chk("rst_done", 32'(read_done), 32'd0);
    chk("rst_addr", 32'(rd_addr), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    rst = 1'b0;
    do_load = 1'b0;
    sample_valid = 1'b0;
    step();

    // Full load with do_load held high, then single readback.
    fill("full", 0, 0, DEPTH);
`ifdef READBACK_LOOP_EN
    readback("loop", -1, 2);
`else
    readback("rb1", -1, 1);
    hold_done("rb1");

    // Restart from DONE with a stalled feed.
    do_load = 1'b0;
    step();
    fill("stall", 2, 1, 3 * (DEPTH - 1) + 1);
    readback("rb2", -1, 1);

    // Abort mid-read, then reload with all ones.
    do_load = 1'b0;
    step();
    fill("pre_abort", 0, 0, DEPTH);
    readback("abort", 100, 1);
    fill("ones", 1, 0, 0);
    readback("rb3", -1, 1);
    hold_done("rb3");

    // Reset in the middle of a load.
    do_load = 1'b0;
    step();
    do_load = 1'b1;
    sample_valid = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("mid_we", 32'(write_enable), 32'd1);
    rst = 1'b1;
    do_load = 1'b0;
    sample_valid = 1'b0;
    step();
    chk("mid_rst_we", 32'(write_enable), 32'd0);
    chk("mid_rst_dl", 32'(data_loaded), 32'd0);
    chk("mid_rst_addr", 32'(rd_addr), 32'd0);
    rst = 1'b0;
    step();
    step();
    chk("post_rst_idle_we", 32'(write_enable), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
